// File: rtl/trdmac_slv_pkg.sv
// Shared types and constants for the transpose-DMA AXI3 memory responder.
//   w_state_e / r_state_e : write and read channel FSM states
//   RESP_* / BURST_* / SIZE_4B : AXI3 encodings used by the responder
package trdmac_slv_pkg;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned LEN_W  = 4;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [2:0] SIZE_4B = 3'b010;

  // Per-burst response: unsupported size/burst type outranks an address miss.
  function automatic logic [1:0] burst_resp(input logic [2:0] size,
                                            input logic [1:0] burst,
                                            input logic       out_of_range);
    if (size != SIZE_4B || (burst != BURST_FIXED && burst != BURST_INCR)) begin
      return RESP_SLVERR;
    end
    if (out_of_range) begin
      return RESP_DECERR;
    end
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/trdmac_slv_mem.sv
// Word-addressed flop memory: 2^AW x 32, one byte-enabled synchronous write
// port, one asynchronous read port (a same-cycle write is seen next cycle).
//   clk                  : clock
//   we_i/waddr_i/wdata_i/wstrb_i : write port
//   raddr_i/rdata_o      : combinational read port
module trdmac_slv_mem
  import trdmac_slv_pkg::*;
#(
  parameter int unsigned AW = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (wstrb_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/trdmac_axi_mem_slave.sv
// AXI3 responder backed by on-chip memory; independent write (AW/W/B) and
// read (AR/R) FSMs, one burst in flight per direction.
//   clk, rst_n          : clock, asynchronous active-low reset
//   aw*/w*/b*           : write address, data and response channels
//   ar*/r*              : read address and data channels
// Optional build macro TRDMAC_SLV_WLAST_CHK_EN: a wlast_i that disagrees with
// the awlen beat count turns an OKAY write response into SLVERR.
module trdmac_axi_mem_slave
  import trdmac_slv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_AW    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   awid_i,
  input  logic [ADDR_W-1:0] awaddr_i,
  input  logic [LEN_W-1:0]  awlen_i,
  input  logic [2:0]        awsize_i,
  input  logic [1:0]        awburst_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [ID_W-1:0]   wid_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic              wlast_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [ID_W-1:0]   bid_o,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready_i,
  input  logic [ID_W-1:0]   arid_i,
  input  logic [ADDR_W-1:0] araddr_i,
  input  logic [LEN_W-1:0]  arlen_i,
  input  logic [2:0]        arsize_i,
  input  logic [1:0]        arburst_i,
  input  logic              arvalid_i,
  output logic              arready_o,
  output logic [ID_W-1:0]   rid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        rresp_o,
  output logic              rlast_o,
  output logic              rvalid_o,
  input  logic              rready_i
);

  w_state_e          w_state_q;
  logic [ID_W-1:0]   w_id_q;
  logic [MEM_AW-1:0] w_idx_q;
  logic [LEN_W-1:0]  w_len_q;
  logic [LEN_W-1:0]  w_beat_q;
  logic [1:0]        w_burst_q;
  logic [1:0]        w_resp_q;
  logic              w_drop_q;

  r_state_e          r_state_q;
  logic [ID_W-1:0]   r_id_q;
  logic [MEM_AW-1:0] r_idx_q;
  logic [LEN_W-1:0]  r_len_q;
  logic [LEN_W-1:0]  r_beat_q;
  logic [1:0]        r_burst_q;
  logic [1:0]        r_resp_q;
  logic [DATA_W-1:0] rdata_q;

  logic [ADDR_W:0]   aw_diff;
  logic [ADDR_W:0]   ar_diff;
  logic [MEM_AW-1:0] aw_idx;
  logic [MEM_AW-1:0] ar_idx;
  logic [1:0]        aw_resp;
  logic [1:0]        ar_resp;
  logic [MEM_AW-1:0] r_next_idx;
  logic [MEM_AW-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;

  // Address decode: bit ADDR_W of the extended difference is the borrow (addr < base).
  always_comb begin
    aw_diff = (ADDR_W+1)'(awaddr_i) - (ADDR_W+1)'(BASE_ADDR);
    ar_diff = (ADDR_W+1)'(araddr_i) - (ADDR_W+1)'(BASE_ADDR);
    aw_idx  = aw_diff[MEM_AW+1:2];
    ar_idx  = ar_diff[MEM_AW+1:2];
    aw_resp = burst_resp(awsize_i, awburst_i, (aw_diff[ADDR_W:MEM_AW+2] != '0));
    ar_resp = burst_resp(arsize_i, arburst_i, (ar_diff[ADDR_W:MEM_AW+2] != '0));
  end

  // Read port: AR address while idle, otherwise the next beat's word.
  always_comb begin
    r_next_idx = (r_burst_q == BURST_INCR) ? r_idx_q + MEM_AW'(1) : r_idx_q;
    mem_raddr  = (r_state_q == R_IDLE) ? ar_idx : r_next_idx;
    mem_we     = (w_state_q == W_DATA) && wvalid_i && !w_drop_q;
  end

  trdmac_slv_mem #(.AW(MEM_AW)) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (w_idx_q),
    .wdata_i (wdata_i),
    .wstrb_i (wstrb_i),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  // Write channel FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_burst_q <= '0;
      w_resp_q  <= RESP_OKAY;
      w_drop_q  <= 1'b0;
    end else begin
      unique case (w_state_q)
        W_IDLE: begin
          if (awvalid_i) begin
            w_id_q    <= awid_i;
            w_idx_q   <= aw_idx;
            w_len_q   <= awlen_i;
            w_beat_q  <= '0;
            w_burst_q <= awburst_i;
            w_resp_q  <= aw_resp;
            w_drop_q  <= (aw_resp != RESP_OKAY);
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid_i) begin
`ifdef TRDMAC_SLV_WLAST_CHK_EN
            if ((wlast_i != (w_beat_q == w_len_q)) && (w_resp_q == RESP_OKAY)) begin
              w_resp_q <= RESP_SLVERR;
            end
`endif
            if (w_burst_q == BURST_INCR) begin
              w_idx_q <= w_idx_q + MEM_AW'(1);
            end
            w_beat_q <= w_beat_q + LEN_W'(1);
            if (w_beat_q == w_len_q) begin
              w_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready_i) begin
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Read channel FSM; rdata_q is refilled on the handshake cycle so beats run back to back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_burst_q <= '0;
      r_resp_q  <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      unique case (r_state_q)
        R_IDLE: begin
          if (arvalid_i) begin
            r_id_q    <= arid_i;
            r_idx_q   <= ar_idx;
            r_len_q   <= arlen_i;
            r_beat_q  <= '0;
            r_burst_q <= arburst_i;
            r_resp_q  <= ar_resp;
            rdata_q   <= (ar_resp == RESP_OKAY) ? mem_rdata : '0;
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready_i) begin
            if (r_beat_q == r_len_q) begin
              r_state_q <= R_IDLE;
            end else begin
              r_idx_q  <= r_next_idx;
              r_beat_q <= r_beat_q + LEN_W'(1);
              rdata_q  <= (r_resp_q == RESP_OKAY) ? mem_rdata : '0;
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign awready_o = (w_state_q == W_IDLE);
  assign wready_o  = (w_state_q == W_DATA);
  assign bvalid_o  = (w_state_q == W_RESP);
  assign bid_o     = w_id_q;
  assign bresp_o   = w_resp_q;

  assign arready_o = (r_state_q == R_IDLE);
  assign rvalid_o  = (r_state_q == R_DATA);
  assign rid_o     = r_id_q;
  assign rresp_o   = r_resp_q;
  assign rdata_o   = rdata_q;
  assign rlast_o   = (r_state_q == R_DATA) && (r_beat_q == r_len_q);

  // Inputs and address bits that carry no meaning for this responder.
  logic unused_bits;
`ifdef TRDMAC_SLV_WLAST_CHK_EN
  assign unused_bits = ^{wid_i, aw_diff[1:0], ar_diff[1:0]};
`else
  assign unused_bits = ^{wid_i, wlast_i, aw_diff[1:0], ar_diff[1:0]};
`endif

endmodule

// File: tb/tb_trdmac_axi_mem_slave.sv
// Directed bench for trdmac_axi_mem_slave: bursts with hand-chosen data,
// a small word-level memory model for read expectations.
module tb_trdmac_axi_mem_slave;
  import trdmac_slv_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awid_i, wid_i, arid_i, bid_o, rid_o;
  logic [31:0] awaddr_i, araddr_i, wdata_i, rdata_o;
  logic [3:0]  awlen_i, arlen_i, wstrb_i;
  logic [2:0]  awsize_i, arsize_i;
  logic [1:0]  awburst_i, arburst_i, bresp_o, rresp_o;
  logic        awvalid_i, awready_o, wlast_i, wvalid_i, wready_o;
  logic        bvalid_o, bready_i, arvalid_i, arready_o;
  logic        rlast_o, rvalid_o, rready_i;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model [int];

  always #5 clk = ~clk;

  trdmac_axi_mem_slave #(.BASE_ADDR(BASE), .MEM_AW(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
    .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
    .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
    .rvalid_o(rvalid_o), .rready_i(rready_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int word_idx(input logic [31:0] addr);
    return int'(((addr - BASE) >> 2) & 32'h3FF);
  endfunction

  // Beat b carries d0*(b+1); wlast_i is raised on beat last_beat.
  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                             input logic [31:0] d0, input int last_beat, input logic [1:0] exp_resp,
                             input bit drop, input bit b_stall);
    int idx;
    int t;
    logic [31:0] v;
    awid_i = id; awaddr_i = addr; awlen_i = len; awsize_i = size; awburst_i = burst;
    awvalid_i = 1'b1;
    t = 0;
    while (!awready_o && t < 50) begin @(posedge clk); #1; t++; end
    chk("aw_ready", 32'(awready_o), 32'd1);
    @(posedge clk); #1;
    awvalid_i = 1'b0;
    chk("wready_after_aw", 32'(wready_o), 32'd1);
    idx = word_idx(addr);
    for (int b = 0; b <= int'(len); b++) begin
      wid_i = id; wdata_i = d0 * 32'(b + 1); wstrb_i = strb;
      wlast_i = (b == last_beat); wvalid_i = 1'b1;
      t = 0;
      while (!wready_o && t < 50) begin @(posedge clk); #1; t++; end
      chk("w_ready", 32'(wready_o), 32'd1);
      @(posedge clk); #1;
      if (!drop) begin
        v = model.exists(idx) ? model[idx] : 32'h0;
        for (int k = 0; k < 4; k++) if (strb[k]) v[8*k +: 8] = wdata_i[8*k +: 8];
        model[idx] = v;
      end
      if (burst == BURST_INCR) idx = (idx + 1) % 1024;
    end
    wvalid_i = 1'b0; wlast_i = 1'b0;
    chk("bvalid_after_last", 32'(bvalid_o), 32'd1);
    chk("bresp", 32'(bresp_o), 32'(exp_resp));
    chk("bid", 32'(bid_o), 32'(id));
    if (b_stall) begin
      repeat ($urandom_range(1, 4)) begin
        @(posedge clk); #1;
        chk("bvalid_hold", 32'(bvalid_o), 32'd1);
        chk("bresp_hold", 32'(bresp_o), 32'(exp_resp));
      end
    end
    bready_i = 1'b1;
    @(posedge clk); #1;
    bready_i = 1'b0;
    chk("bvalid_clear", 32'(bvalid_o), 32'd0);
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input logic [2:0] size,
                            input logic [1:0] exp_resp, input bit stall);
    int idx;
    int b;
    int t;
    logic [31:0] exp;
    arid_i = id; araddr_i = addr; arlen_i = len; arsize_i = size; arburst_i = burst;
    arvalid_i = 1'b1;
    t = 0;
    while (!arready_o && t < 50) begin @(posedge clk); #1; t++; end
    chk("ar_ready", 32'(arready_o), 32'd1);
    @(posedge clk); #1;
    arvalid_i = 1'b0;
    idx = word_idx(addr);
    b = 0; t = 0;
    while (b <= int'(len) && t < 300) begin
      exp = (exp_resp == RESP_OKAY && model.exists(idx)) ? model[idx] : 32'h0;
      chk("rvalid", 32'(rvalid_o), 32'd1);
      chk("rdata", rdata_o, exp);
      chk("rresp", 32'(rresp_o), 32'(exp_resp));
      chk("rid", 32'(rid_o), 32'(id));
      chk("rlast", 32'(rlast_o), 32'(b == int'(len)));
      rready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      if (rready_i) begin
        b++;
        if (burst == BURST_INCR) idx = (idx + 1) % 1024;
      end
      t++;
    end
    rready_i = 1'b0;
    chk("r_beats_done", 32'(b), 32'(len) + 32'd1);
    chk("rvalid_clear", 32'(rvalid_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    awid_i = '0; awaddr_i = '0; awlen_i = '0; awsize_i = '0; awburst_i = '0; awvalid_i = 1'b0;
    wid_i = '0; wdata_i = '0; wstrb_i = '0; wlast_i = 1'b0; wvalid_i = 1'b0; bready_i = 1'b0;
    arid_i = '0; araddr_i = '0; arlen_i = '0; arsize_i = '0; arburst_i = '0; arvalid_i = 1'b0;
    rready_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(awready_o), 32'd1);
    chk("rst_arready", 32'(arready_o), 32'd1);
    chk("rst_wready", 32'(wready_o), 32'd0);
    chk("rst_bvalid", 32'(bvalid_o), 32'd0);
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_rlast", 32'(rlast_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_bresp", 32'(bresp_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic INCR write then back-to-back readback.
    write_burst(4'h5, 32'h100, 4'd3, SIZE_4B, BURST_INCR, 4'hF, 32'h11, 3, RESP_OKAY, 1'b0, 1'b0);
    read_burst(4'h6, 32'h100, 4'd3, BURST_INCR, SIZE_4B, RESP_OKAY, 1'b0);

    // Index wrap at the top of memory.
    write_burst(4'h2, 32'hFFC, 4'd1, SIZE_4B, BURST_INCR, 4'hF, 32'h0BAD_0001, 1, RESP_OKAY, 1'b0, 1'b0);
    read_burst(4'h2, 32'hFFC, 4'd1, BURST_INCR, SIZE_4B, RESP_OKAY, 1'b0);

    // Byte strobes: 0xAABBCCDD with 4'b0101 over zero.
    write_burst(4'h1, 32'h0, 4'd0, SIZE_4B, BURST_INCR, 4'hF, 32'h0, 0, RESP_OKAY, 1'b0, 1'b0);
    write_burst(4'h1, 32'h0, 4'd0, SIZE_4B, BURST_INCR, 4'b0101, 32'hAABB_CCDD, 0, RESP_OKAY, 1'b0, 1'b0);
    model[0] = 32'h00BB_00DD;
    read_burst(4'h1, 32'h0, 4'd0, BURST_INCR, SIZE_4B, RESP_OKAY, 1'b0);

    // FIXED burst: every beat hits the same word; last beat wins.
    write_burst(4'h3, 32'h140, 4'd2, SIZE_4B, BURST_FIXED, 4'hF, 32'h10, 2, RESP_OKAY, 1'b0, 1'b0);
    read_burst(4'h3, 32'h140, 4'd2, BURST_FIXED, SIZE_4B, RESP_OKAY, 1'b0);

    // Error bursts: bad size dropped, out-of-range decode, bad burst type.
    write_burst(4'h4, 32'h180, 4'd2, SIZE_4B, BURST_INCR, 4'hF, 32'h1000, 2, RESP_OKAY, 1'b0, 1'b0);
    write_burst(4'h9, 32'h180, 4'd2, 3'b001, BURST_INCR, 4'hF, 32'hDEAD, 2, RESP_SLVERR, 1'b1, 1'b0);
    read_burst(4'h4, 32'h180, 4'd2, BURST_INCR, SIZE_4B, RESP_OKAY, 1'b0);
    write_burst(4'hA, 32'h2000, 4'd1, SIZE_4B, BURST_INCR, 4'hF, 32'hBEEF, 1, RESP_DECERR, 1'b1, 1'b0);
    read_burst(4'hB, BASE + 32'd4096, 4'd2, BURST_INCR, SIZE_4B, RESP_DECERR, 1'b0);
    read_burst(4'hC, 32'h100, 4'd1, 2'b10, SIZE_4B, RESP_SLVERR, 1'b0);

    // Early wlast on beat 1 of a 4-beat burst.
`ifdef TRDMAC_SLV_WLAST_CHK_EN
    write_burst(4'hD, 32'h1C0, 4'd3, SIZE_4B, BURST_INCR, 4'hF, 32'h7, 1, RESP_SLVERR, 1'b0, 1'b0);
`else
    write_burst(4'hD, 32'h1C0, 4'd3, SIZE_4B, BURST_INCR, 4'hF, 32'h7, 1, RESP_OKAY, 1'b0, 1'b0);
`endif
    read_burst(4'hD, 32'h1C0, 4'd3, BURST_INCR, SIZE_4B, RESP_OKAY, 1'b0);

    // Concurrent write and stalled read.
    write_burst(4'h7, 32'h300, 4'd15, SIZE_4B, BURST_INCR, 4'hF, 32'h0101_0101, 15, RESP_OKAY, 1'b0, 1'b0);
    fork
      write_burst(4'h8, 32'h200, 4'd7, SIZE_4B, BURST_INCR, 4'hF, 32'h0200_0003, 7, RESP_OKAY, 1'b0, 1'b1);
      read_burst(4'hE, 32'h300, 4'd15, BURST_INCR, SIZE_4B, RESP_OKAY, 1'b1);
    join
    read_burst(4'h8, 32'h200, 4'd7, BURST_INCR, SIZE_4B, RESP_OKAY, 1'b1);

    // Reset while beat 2 of a read is presented.
    arid_i = 4'hF; araddr_i = 32'h100; arlen_i = 4'd3; arsize_i = SIZE_4B; arburst_i = BURST_INCR;
    arvalid_i = 1'b1;
    @(posedge clk); #1;
    arvalid_i = 1'b0;
    rready_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_rdata", rdata_o, 32'h33);
    rready_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midburst_rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("midburst_rst_rlast", 32'(rlast_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_arready", 32'(arready_o), 32'd1);
    chk("post_rst_rvalid", 32'(rvalid_o), 32'd0);
    read_burst(4'h6, 32'h100, 4'd3, BURST_INCR, SIZE_4B, RESP_OKAY, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
